brdg_interrupt_mc: RTL
======================

BRDG_INTERRUPT_MC -- requirements
Module: brdg_interrupt_mc

Interface
Parameters:
REQ-001 SHALL have parameter NUM_CH, default 4; number of independent interrupt channels, legal range 1..16.
REQ-002 SHALL have parameter BASE_CYC, default 20; backoff base count in clock cycles, i.e. 100 ns at 200 MHz.

Ports:
REQ-003 SHALL have port clk  input  1  sole clock; all logic rising-edge.
REQ-004 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-005 SHALL have port backoff_limit  input  4  retry backoff exponent.
REQ-006 SHALL have port interrupt_enable  input  1  global permission to issue commands.
REQ-007 SHALL have port interrupt  input  NUM_CH  per-channel request level.
REQ-008 SHALL have port interrupt_src  input  64*NUM_CH  per-channel 64-bit source handle; channel i at bits [64i+63:64i].
REQ-009 SHALL have port interrupt_ack  output  NUM_CH  per-channel acknowledge level.
REQ-010 SHALL have port interrupt_fail  output  NUM_CH  per-channel sticky failure flag.
REQ-011 SHALL have port tlx_cmd_valid  output  1  command strobe.
REQ-012 SHALL have port tlx_cmd_obj  output  68  {4'd0, src}.
REQ-013 SHALL have port tlx_cmd_afutag  output  16  {2'b11, 10'd0, channel[3:0]}.
REQ-014 SHALL have port tlx_cmd_opcode  output  8  8'h58 (intrp_req).
REQ-015 SHALL have ports tlx_rsp_valid (1), tlx_rsp_afutag (16), tlx_rsp_opcode (8) and tlx_rsp_code (4), all inputs; TLX response bus.

Function
Source capture and channel states:
REQ-016 SHALL capture interrupt_src slice i into a per-channel register while channel i is IDLE and interrupt[i]=1; retries reuse the captured value.
REQ-017 SHALL give each channel its own state machine: IDLE, SEND, WAIT_RSP, PENDING, BACKOFF, ACK.
REQ-018 SHALL move IDLE->SEND when interrupt[i]=1.

Arbitration and command issue:
REQ-019 SHALL grant SEND channels round-robin, at most one per cycle, and only while interrupt_enable=1.
REQ-020 SHALL start the search one position after the last granted channel, wrapping NUM_CH-1 -> 0.
REQ-021 SHALL, for the channel granted in cycle t, move it to WAIT_RSP at t+1 and drive tlx_cmd_valid=1 with that channel's obj/afutag at t+1 (one registered stage).
REQ-022 SHALL drive tlx_cmd_valid=0 in every cycle following a cycle with no grant.
REQ-023 SHALL keep channels in SEND indefinitely while interrupt_enable=0, issuing nothing.

Response decode (opcode 8'h0C) for the matching channel:
REQ-024 SHALL route a response to channel tlx_rsp_afutag[3:0] only if afutag[15:14]=2'b11 and afutag[3:0]<NUM_CH; otherwise ignore it.
REQ-025 SHALL, in WAIT_RSP, map code 0 -> ACK, 2 -> BACKOFF and 4 -> PENDING.
REQ-026 SHALL, in WAIT_RSP, map any other code -> ACK with interrupt_fail[i] set.

Ready notification (opcode 8'h1A) for the matching channel:
REQ-027 SHALL, in PENDING, map code 0 -> SEND and code 2 -> BACKOFF; other codes are ignored.
REQ-028 SHALL ignore any response whose target channel is not in the state that expects it, with no state change.

Backoff:
REQ-029 SHALL load a per-channel 24-bit counter with BASE_CYC << backoff_limit on entry to BACKOFF (e.g. limit 15 -> 24'h0A_0000).
REQ-030 SHALL decrement the counter once per cycle in BACKOFF and move to SEND in the cycle after the counter reads 0.
REQ-031 SHALL use the backoff_limit value sampled at BACKOFF entry; changes during BACKOFF have no effect.

Acknowledge and fail flag:
REQ-032 SHALL hold interrupt_ack[i]=1 while channel i is in ACK, and move ACK->IDLE once interrupt[i]=0.
REQ-033 SHALL clear interrupt_fail[i] on the IDLE->SEND transition of channel i.

Concurrency:
REQ-034 SHALL let channels progress concurrently: one response and one grant in the same cycle, on the same or different channels, are both honoured.
REQ-035 SHALL let a channel re-entering SEND from PENDING or BACKOFF compete in arbitration in the next cycle.

Reset
REQ-036 SHALL, with rst=1 at a clk edge, set all channels to IDLE and all outputs to 0 (including tlx_cmd_obj, afutag and opcode), clear the backoff counters and the fail flags, and reset the round-robin pointer so channel 0 has first priority.
REQ-037 SHALL, on reset asserted mid-transaction, abandon all outstanding requests; any late responses are ignored because every channel is IDLE.

Verification
REQ-038 SHALL cover: ch1 interrupt, src=64'h1234 -> one cmd, afutag 16'hC001, obj 68'h1234; rsp 0x0C/code 0 -> ack[1]=1 until interrupt[1] drops.
REQ-039 SHALL cover: all 4 channels requesting in the same cycle -> cmds issued in 4 consecutive cycles in order 0,1,2,3; a later ch0 request waits behind pointer position.
REQ-040 SHALL cover: ch2 gets retry with backoff_limit=0 -> reissue exactly 20 cycles after BACKOFF entry (+1 cycle), with the same obj.
REQ-041 SHALL cover: ch3 pending, then 0x1A/code 0 -> reissue; then 0x0C/code 0xE -> ack[3]=1 and fail[3]=1.
REQ-042 SHALL cover: interrupt_enable=0 while requests are held -> no cmds; enable raised -> issue resumes in round-robin order.
REQ-043 SHALL cover: rst pulsed during ch0 WAIT_RSP, then done response -> ignored, all outputs 0.

Source files
------------

// File: rtl/brdg_interrupt_mc.sv
// Multi-channel interrupt bridge: per-channel request FSMs share one TLX command port
// through a round-robin arbiter and are retired by decoded TLX responses.
module brdg_interrupt_mc #(
  parameter int NUM_CH   = 4,
  parameter int BASE_CYC = 20
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [3:0]             backoff_limit,
  input  logic                   interrupt_enable,
  input  logic [NUM_CH-1:0]      interrupt,
  input  logic [64*NUM_CH-1:0]   interrupt_src,
  output logic [NUM_CH-1:0]      interrupt_ack,
  output logic [NUM_CH-1:0]      interrupt_fail,
  output logic                   tlx_cmd_valid,
  output logic [67:0]            tlx_cmd_obj,
  output logic [15:0]            tlx_cmd_afutag,
  output logic [7:0]             tlx_cmd_opcode,
  input  logic                   tlx_rsp_valid,
  input  logic [15:0]            tlx_rsp_afutag,
  input  logic [7:0]             tlx_rsp_opcode,
  input  logic [3:0]             tlx_rsp_code
);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    SEND     = 3'd1,
    WAIT_RSP = 3'd2,
    PENDING  = 3'd3,
    BACKOFF  = 3'd4,
    ACK      = 3'd5
  } ch_state_t;

  localparam logic [7:0] OP_INTRP_REQ = 8'h58;
  localparam logic [7:0] OP_INTRP_RSP = 8'h0C;
  localparam logic [7:0] OP_INTRP_RDY = 8'h1A;

  logic [3:0]           rsp_ch;
  logic                 rsp_hit;
  logic [23:0]          backoff_load;
  logic [NUM_CH-1:0]    send_ch;
  logic [15:0]          send_vec;
  logic [64*NUM_CH-1:0] src_flat;
  logic                 grant_valid;
  logic [3:0]           grant_idx;
  logic [63:0]          grant_src;
  logic [3:0]           ptr_r;
  int                   idx;

  assign rsp_ch       = tlx_rsp_afutag[3:0];
  assign rsp_hit      = tlx_rsp_valid && (tlx_rsp_afutag[15:14] == 2'b11) &&
                        ({1'b0, rsp_ch} < 5'(NUM_CH));
  assign backoff_load = 24'(BASE_CYC) << backoff_limit;

  genvar i;
  generate
    for (i = 0; i < NUM_CH; i++) begin : g_ch
      ch_state_t   state_r, state_nx;
      logic [63:0] src_r, src_nx;
      logic [23:0] cnt_r, cnt_nx;
      logic        fail_r, fail_nx;
      logic        ack_r;
      logic        grant_s;
      logic        rsp_s;

      assign grant_s           = grant_valid && (grant_idx == 4'(i));
      assign rsp_s             = rsp_hit && (rsp_ch == 4'(i));
      assign send_ch[i]        = (state_r == SEND);
      assign src_flat[64*i +: 64] = src_r;
      assign interrupt_ack[i]  = ack_r;
      assign interrupt_fail[i] = fail_r;

      // Channel next-state: request capture, response decode and backoff countdown
      always_comb begin
        state_nx = state_r;
        src_nx   = src_r;
        cnt_nx   = cnt_r;
        fail_nx  = fail_r;
        case (state_r)
          IDLE: begin
            if (interrupt[i]) begin
              state_nx = SEND;
              src_nx   = interrupt_src[64*i +: 64];
              fail_nx  = 1'b0;
            end else begin
              state_nx = IDLE;
            end
          end
          SEND: begin
            if (grant_s) state_nx = WAIT_RSP;
            else         state_nx = SEND;
          end
          WAIT_RSP: begin
            if (rsp_s && (tlx_rsp_opcode == OP_INTRP_RSP)) begin
              case (tlx_rsp_code)
                4'd0:    state_nx = ACK;
                4'd2:    begin state_nx = BACKOFF; cnt_nx = backoff_load; end
                4'd4:    state_nx = PENDING;
                default: begin state_nx = ACK; fail_nx = 1'b1; end
              endcase
            end else begin
              state_nx = WAIT_RSP;
            end
          end
          PENDING: begin
            if (rsp_s && (tlx_rsp_opcode == OP_INTRP_RDY)) begin
              case (tlx_rsp_code)
                4'd0:    state_nx = SEND;
                4'd2:    begin state_nx = BACKOFF; cnt_nx = backoff_load; end
                default: state_nx = PENDING;
              endcase
            end else begin
              state_nx = PENDING;
            end
          end
          BACKOFF: begin
            if (cnt_r == 24'd0) begin
              state_nx = SEND;
            end else begin
              state_nx = BACKOFF;
              cnt_nx   = cnt_r - 24'd1;
            end
          end
          ACK: begin
            if (!interrupt[i]) state_nx = IDLE;
            else               state_nx = ACK;
          end
          default: state_nx = IDLE;
        endcase
      end

      // Channel state, captured source, counter and flag registers
      always_ff @(posedge clk) begin
        if (rst) begin
          state_r <= IDLE;
          src_r   <= 64'd0;
          cnt_r   <= 24'd0;
          fail_r  <= 1'b0;
          ack_r   <= 1'b0;
        end else begin
          state_r <= state_nx;
          src_r   <= src_nx;
          cnt_r   <= cnt_nx;
          fail_r  <= fail_nx;
          ack_r   <= (state_nx == ACK);
        end
      end
    end
  endgenerate

  // Pad the SEND mask to 16 entries so the wrapped search index is always in range
  always_comb begin
    send_vec              = 16'd0;
    send_vec[NUM_CH-1:0]  = send_ch;
  end

  // Round-robin search starting one past the last granted channel
  always_comb begin
    grant_valid = 1'b0;
    grant_idx   = 4'd0;
    idx         = 0;
    for (int k = 1; k <= NUM_CH; k++) begin
      idx = ((int'(ptr_r) + k) >= NUM_CH) ? (int'(ptr_r) + k - NUM_CH) : (int'(ptr_r) + k);
      grant_idx   = (interrupt_enable && !grant_valid && send_vec[idx[3:0]]) ? idx[3:0] : grant_idx;
      grant_valid = grant_valid | (interrupt_enable && send_vec[idx[3:0]]);
    end
  end

  // Source mux for the granted channel
  always_comb begin
    grant_src = 64'd0;
    for (int c = 0; c < NUM_CH; c++) begin
      grant_src = (grant_idx == 4'(c)) ? src_flat[64*c +: 64] : grant_src;
    end
  end

  // Registered command stage and round-robin pointer
  always_ff @(posedge clk) begin
    if (rst) begin
      tlx_cmd_valid  <= 1'b0;
      tlx_cmd_obj    <= 68'd0;
      tlx_cmd_afutag <= 16'd0;
      tlx_cmd_opcode <= 8'd0;
      ptr_r          <= 4'(NUM_CH - 1);
    end else begin
      tlx_cmd_valid <= grant_valid;
      if (grant_valid) begin
        tlx_cmd_obj    <= {4'd0, grant_src};
        tlx_cmd_afutag <= {2'b11, 10'd0, grant_idx};
        tlx_cmd_opcode <= OP_INTRP_REQ;
        ptr_r          <= grant_idx;
      end
    end
  end

endmodule
